design1_wrapper: RTL and testbench
==================================

# design1_wrapper

Serial point-to-point link endpoint that moves 256-bit words between a local write FIFO and a remote read FIFO over a single 1-bit differential lane. It sits at the top of the matrix-multiplier transport path: the user side sees two FIFO interfaces, and the lane side drives `txp`/`txn` and receives `rxp`/`rxn`. It includes its own framing, lane alignment (`channel_up`) and error reporting. Tying `rxp`/`rxn` to `txp`/`txn` gives a self-loopback.

## Interface
- `FIFO_DEPTH`, 16: depth in words of each of the TX and RX FIFOs (power of two).
- `LOCK_COUNT`, 4: number of consecutive correctly spaced headers required to raise `channel_up`.
- `clk_200MHz` input 1: the single clock; all logic is on its rising edge.
- `peripheral_aresetn` input 1: asynchronous, active-low reset. Assertion clears all state immediately. Release is synchronised internally (2-flop).
- `din` input 256: TX word.
- `wr_en` input 1: push `din` into the TX FIFO. Ignored when `full` = 1.
- `full` output 1: TX FIFO full.
- `dout` output 256: head of the RX FIFO (first-word fall-through); 0 when empty.
- `rd_en` input 1: pop the RX FIFO. Ignored when `not_empty` = 0.
- `not_empty` output 1: RX FIFO holds at least one word.
- `txp`, `txn` output 1 each: lane out; `txn` is always `~txp`.
- `rxp`, `rxn` input 1 each: lane in; only `rxp` is sampled.
- `channel_up` output 1: receiver aligned.
- `Error` output 1: sticky error flag.
- `user_clk`, `init_clk`, `gt_refclk` output 1 each: direct copies of `clk_200MHz`.

## Operation
- **Frame format:** 264 bits, one bit per clock, MSB first.
  - 8-bit header: 8'hD5 = data frame, 8'h3C = idle frame.
  - 256-bit payload: the word for a data frame; all zeros for an idle frame.
- **TX:**
  - A free-running bit counter runs 0..263 from reset release.
  - At bit 0 the transmitter chooses the frame type. If `channel_up` = 1 and the TX FIFO is non-empty, it pops the head word and sends a data frame. Otherwise it sends an idle frame.
  - Once started, a frame is never aborted.
- **RX states:**
  - HUNT: shift `rxp` into an 8-bit window. When the window equals D5 or 3C, go to VERIFY with count = 1.
  - VERIFY: 264 bits after the previous header, check the window.
    - Valid header: count+1; when count reaches `LOCK_COUNT`, go to UP.
    - Invalid header: go to HUNT (no error).
  - UP: `channel_up` = 1 and headers are checked every 264 bits.
    - D5 header: the following 256 bits are assembled and written to the RX FIFO.
    - 3C header: the payload is discarded.
    - Any other header: set `Error`, go to HUNT, `channel_up` = 0.
- **FIFOs:** TX and RX FIFOs are independent synchronous FIFOs of `FIFO_DEPTH` words.
  - Simultaneous read and write on a non-full, non-empty FIFO both take effect.
  - A completed data frame arriving while the RX FIFO is full is dropped and sets `Error`.
- **Error:** cleared only by reset.
- **Reset values:** `txp` = 0, `txn` = 1, `channel_up` = 0, `Error` = 0, `full` = 0, `not_empty` = 0, `dout` = 0. Both FIFOs are emptied and RX is in HUNT.
- **Reset mid-frame:** any partial frame is abandoned. After release, TX restarts at bit 0 with an idle frame.

## Timing
- `full` and `not_empty` update the cycle after the push or pop that changes them.
- `wr_en` while `full` = 1 and `rd_en` while `not_empty` = 0 are ignored; no state change.
- `rxp` is registered once before the window shift register.
- The RX FIFO write occurs the cycle after the last payload bit is registered; `not_empty` rises one cycle later.
- Loopback, from reset release:
  - The first header is found about 9 cycles in.
  - `channel_up` rises about (`LOCK_COUNT`−1)×264 + 10 cycles after release, ≤ 1100 cycles with defaults.
- Loopback word latency, from the `wr_en` cycle with `channel_up` = 1: at most 264 (wait for a boundary) + 264 (frame) + 4 cycles until `not_empty` = 1.
- `channel_up` falls the cycle after a bad header is registered.
- `Error` rises in the same cycle as that `channel_up` fall, or in the cycle of the dropped RX write.

## Test plan
- **Reset and lock:** reset low for 16 ns, then high, with loopback wiring. Required:
  - All outputs hold their reset values during reset.
  - `txn` = `~txp` at all times.
  - `channel_up` = 1 within 1100 cycles.
  - `Error` = 0.
- **Single word:** after `channel_up`, write `din` = 256'h0123…CDEF once. Required: `not_empty` = 1 within 532 cycles, `dout` equals the written word, `rd_en` for one cycle makes `not_empty` = 0.
- **Order and full:** write 17 distinct words with `channel_up` = 0 held in reset release (rx tied to 0). Required: `full` = 1 after 16 writes; the 17th write is ignored; after connecting loopback, exactly 16 words arrive in order.
- **RX overflow:** loopback, never assert `rd_en`, write 17 words. Required: 16 stored, `Error` = 1, `channel_up` stays 1.
- **Corrupted header:** in UP, invert `rxp` for the 8 header bits of one frame. Required: `channel_up` → 0 next cycle, `Error` = 1, relock within 1100 cycles, `Error` stays 1.
- **Reset mid-frame:** assert `peripheral_aresetn` = 0 in the middle of a data frame. Required: immediate reset values, both FIFOs empty, normal relock after release.

Source files
------------

// File: rtl/design1_wrapper.sv
// Serial link endpoint: 256-bit words framed as 8-bit header + 256-bit payload,
// one bit per clock over a single lane, with header-spacing lock and sticky error.
module design1_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 256
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         not_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_wr, do_rd;

  assign full      = (cnt == (AW+1)'(DEPTH));
  assign not_empty = (cnt != '0);
  assign do_wr     = wr && !full;
  assign do_rd     = rd && not_empty;
  // first-word fall-through head, forced to zero when empty
  assign rdata     = not_empty ? mem[rp] : '0;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge gclk) begin
    if (do_wr) mem[wp] <= wdata;
  end
endmodule

module design1_wrapper #(
  parameter int FIFO_DEPTH = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic         clk_200MHz,
  input  logic         peripheral_aresetn,
  input  logic [255:0] din,
  input  logic         wr_en,
  output logic         full,
  output logic [255:0] dout,
  input  logic         rd_en,
  output logic         not_empty,
  output logic         txp,
  output logic         txn,
  input  logic         rxp,
  input  logic         rxn,
  output logic         channel_up,
  output logic         Error,
  output logic         user_clk,
  output logic         init_clk,
  output logic         gt_refclk
);
  localparam logic [7:0] HDR_DATA = 8'hD5;
  localparam logic [7:0] HDR_IDLE = 8'h3C;
  localparam logic [8:0] LAST_BIT = 9'd263;
  localparam logic [8:0] HDR_GAP  = 9'd264;
  localparam logic [8:0] PAY_DONE = 9'd256;
  localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {HUNT, VERIFY, UP} rx_state_t;

  logic lane_unused;
  assign lane_unused = rxn;

  assign user_clk  = clk_200MHz;
  assign init_clk  = clk_200MHz;
  assign gt_refclk = clk_200MHz;

  // reset asserts asynchronously, releases two clocks later
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge clk_200MHz or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) rst_sync <= '0;
    else                     rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // ---------------- TX ----------------
  logic [8:0]   tx_bit;
  logic [263:0] tx_sr, tx_frame;
  logic [255:0] tx_head;
  logic         tx_ne, tx_pop;

  assign tx_pop   = (tx_bit == '0) && channel_up && tx_ne;
  assign tx_frame = tx_pop ? {HDR_DATA, tx_head} : {HDR_IDLE, 256'h0};
  assign txn      = ~txp;

  always_ff @(posedge clk_200MHz or negedge rst_n) begin
    if (!rst_n) begin
      tx_bit <= '0;
      tx_sr  <= '0;
      txp    <= 1'b0;
    end else begin
      tx_bit <= (tx_bit == LAST_BIT) ? 9'd0 : tx_bit + 9'd1;
      if (tx_bit == '0) begin
        txp   <= tx_frame[263];
        tx_sr <= {tx_frame[262:0], 1'b0};
      end else begin
        txp   <= tx_sr[263];
        tx_sr <= {tx_sr[262:0], 1'b0};
      end
    end
  end

  design1_fifo #(.DEPTH(FIFO_DEPTH), .W(256)) u_tx_fifo (
    .gclk(clk_200MHz), .grst_n(rst_n),
    .wr(wr_en), .wdata(din), .rd(tx_pop), .rdata(tx_head),
    .full(full), .not_empty(tx_ne)
  );

  // ---------------- RX ----------------
  rx_state_t    state, state_nx;
  logic         rx_q, rx_data, rx_wr, rx_full;
  logic [255:0] rx_sr;
  logic [7:0]   win, lock_cnt;
  logic [8:0]   rx_cnt;
  logic         hdr_ok, at_hdr, bad_hdr;

  assign win     = rx_sr[7:0];
  assign hdr_ok  = (win == HDR_DATA) || (win == HDR_IDLE);
  assign at_hdr  = (rx_cnt == HDR_GAP);
  assign bad_hdr = (state == UP) && at_hdr && !hdr_ok;
  assign rx_wr   = (state == UP) && rx_data && (rx_cnt == PAY_DONE);

  always_ff @(posedge clk_200MHz or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HUNT:   if (hdr_ok) state_nx = (LOCK_N <= 8'd1) ? UP : VERIFY;
      VERIFY: if (at_hdr) begin
                if (!hdr_ok)                        state_nx = HUNT;
                else if (lock_cnt + 8'd1 >= LOCK_N) state_nx = UP;
              end
      UP:     if (bad_hdr) state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  always_comb begin
    channel_up = (state == UP);
  end

  // rx_sr doubles as header window and payload assembler
  always_ff @(posedge clk_200MHz or negedge rst_n) begin
    if (!rst_n) begin
      rx_q     <= 1'b0;
      rx_sr    <= '0;
      rx_cnt   <= 9'd1;
      lock_cnt <= 8'd1;
      rx_data  <= 1'b0;
      Error    <= 1'b0;
    end else begin
      rx_q  <= rxp;
      rx_sr <= {rx_sr[254:0], rx_q};
      if (state == HUNT) begin
        rx_cnt   <= 9'd1;
        lock_cnt <= 8'd1;
        rx_data  <= 1'b0;
      end else if (at_hdr) begin
        rx_cnt   <= 9'd1;
        lock_cnt <= lock_cnt + 8'd1;
        rx_data  <= (win == HDR_DATA) && (state_nx == UP);
      end else begin
        rx_cnt <= rx_cnt + 9'd1;
      end
      if (bad_hdr || (rx_wr && rx_full)) Error <= 1'b1;
    end
  end

  design1_fifo #(.DEPTH(FIFO_DEPTH), .W(256)) u_rx_fifo (
    .gclk(clk_200MHz), .grst_n(rst_n),
    .wr(rx_wr), .wdata(rx_sr), .rd(rd_en), .rdata(dout),
    .full(rx_full), .not_empty(not_empty)
  );
endmodule

// File: tb/tb_design1_wrapper.sv
// Directed sequence with random payloads; expected words come from queues.
`timescale 1ns/1ps
module tb_design1_wrapper;
  logic         clk = 1'b0;
  logic         aresetn;
  logic [255:0] din;
  logic         wr_en, rd_en;
  logic         full, not_empty;
  logic [255:0] dout;
  logic         txp, txn, rxp, rxn;
  logic         channel_up, err;
  logic         user_clk, init_clk, gt_refclk;
  logic         lb, inv;

  int checks = 0;
  int errors = 0;

  always #2.5 clk = ~clk;

  assign rxp = lb ? (txp ^ inv) : 1'b0;
  assign rxn = ~rxp;

  design1_wrapper #(.FIFO_DEPTH(16), .LOCK_COUNT(4)) dut (
    .clk_200MHz(clk), .peripheral_aresetn(aresetn),
    .din(din), .wr_en(wr_en), .full(full),
    .dout(dout), .rd_en(rd_en), .not_empty(not_empty),
    .txp(txp), .txn(txn), .rxp(rxp), .rxn(rxn),
    .channel_up(channel_up), .Error(err),
    .user_clk(user_clk), .init_clk(init_clk), .gt_refclk(gt_refclk)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("txn_inv", {255'h0, txn}, {255'h0, ~txp});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_txp"}, {255'h0, txp}, 256'h0);
    chk({tag, "_txn"}, {255'h0, txn}, 256'h1);
    chk({tag, "_up"}, {255'h0, channel_up}, 256'h0);
    chk({tag, "_err"}, {255'h0, err}, 256'h0);
    chk({tag, "_full"}, {255'h0, full}, 256'h0);
    chk({tag, "_ne"}, {255'h0, not_empty}, 256'h0);
    chk({tag, "_dout"}, dout, 256'h0);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] w = '0;
    for (int i = 0; i < 8; i++) w = {w[223:0], 32'($urandom())};
    return w;
  endfunction

  task automatic push(input logic [255:0] w);
    din = w; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_up(input string tag, input int bound);
    int n = 0;
    while (!channel_up && n < bound) begin tick(); n++; end
    chk(tag, {255'h0, channel_up}, 256'h1);
  endtask

  // pop one word and compare against the expected head
  task automatic pop_chk(input string tag, input logic [255:0] exp, input int bound);
    int n = 0;
    while (!not_empty && n < bound) begin tick(); n++; end
    chk({tag, "_avail"}, {255'h0, not_empty}, 256'h1);
    chk({tag, "_data"}, dout, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_reset(input logic loop);
    aresetn = 1'b0; lb = loop;
    #1;
    chk_reset("rst");
    ticks(3);
    aresetn = 1'b1;
    ticks(2);
  endtask

  initial begin
    logic [255:0] q[$];
    logic [255:0] w;
    logic [7:0]   sw;
    int           n;

    aresetn = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0; lb = 1'b1; inv = 1'b0;

    // reset and lock
    #1;
    chk_reset("por");
    #15;
    aresetn = 1'b1;
    chk("clk_copy", {253'h0, user_clk, init_clk, gt_refclk}, {253'h0, {3{clk}}});
    wait_up("lock", 1100);
    chk("lock_err", {255'h0, err}, 256'h0);

    // single word loopback
    w = 256'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF;
    push(w);
    pop_chk("single", w, 540);
    tick();
    chk("single_empty", {255'h0, not_empty}, 256'h0);

    // corrupted header: locate an idle header on the line, invert the next one
    sw = '0; n = 0;
    while (sw != 8'h3C && n < 600) begin tick(); sw = {sw[6:0], txp}; n++; end
    chk("find_hdr", {248'h0, sw}, {248'h0, 8'h3C});
    ticks(257);
    inv = 1'b1;
    ticks(8);
    inv = 1'b0;
    n = 0;
    while (channel_up && n < 300) begin tick(); n++; end
    chk("corrupt_down", {255'h0, channel_up}, 256'h0);
    chk("corrupt_err", {255'h0, err}, 256'h1);
    wait_up("corrupt_relock", 1100);
    chk("corrupt_err_sticky", {255'h0, err}, 256'h1);

    // reset in the middle of a data frame
    push(rnd256());
    push(rnd256());
    ticks(400);
    aresetn = 1'b0;
    #1;
    chk_reset("midrst");
    ticks(4);
    aresetn = 1'b1;
    wait_up("midrst_relock", 1100);
    ticks(700);
    chk("midrst_rx_empty", {255'h0, not_empty}, 256'h0);
    chk("midrst_err", {255'h0, err}, 256'h0);

    // order and full, receiver held unlocked
    do_reset(1'b0);
    q.delete();
    for (int i = 0; i < 16; i++) begin
      w = rnd256();
      q.push_back(w);
      push(w);
      if (i == 14) chk("full_15", {255'h0, full}, 256'h0);
    end
    chk("full_16", {255'h0, full}, 256'h1);
    push(rnd256());
    chk("full_17", {255'h0, full}, 256'h1);
    lb = 1'b1;
    wait_up("order_lock", 1100);
    for (int i = 0; i < 16; i++) pop_chk("order", q[i], 600);
    ticks(800);
    chk("order_17_dropped", {255'h0, not_empty}, 256'h0);

    // RX overflow: 17 words, no reads
    q.delete();
    for (int i = 0; i < 17; i++) begin
      w = rnd256();
      q.push_back(w);
      n = 0;
      while (full && n < 600) begin tick(); n++; end
      push(w);
    end
    n = 0;
    while (!err && n < 6000) begin tick(); n++; end
    chk("ovf_err", {255'h0, err}, 256'h1);
    chk("ovf_up", {255'h0, channel_up}, 256'h1);
    for (int i = 0; i < 16; i++) pop_chk("ovf", q[i], 10);
    ticks(600);
    chk("ovf_empty", {255'h0, not_empty}, 256'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
